svc_rv_dbg_loader_mc: RTL and testbench

// Multi-hart debug loader engine. It parses a framed byte-stream command protocol

---
 rtl/svc_rv_dbg_loader_mc.sv | 237 +++++++++++++++++++++++
 tb/tb_svc_rv_dbg_loader_mc.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/svc_rv_dbg_loader_mc.sv
// svc_rv_dbg_loader_mc: framed byte-stream debug loader.
// Turns UART command frames into memory reads/writes and hart control.
module svc_rv_dbg_loader_mc #(
    parameter int N_HARTS        = 1,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int RD_LATENCY     = 1,
    parameter int TIMEOUT_CYCLES = 25_000_000,
    parameter bit RESET_STALL    = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [7:0]              in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [7:0]              out_data,
    input  logic                    out_ready,
    output logic                    mem_wen,
    output logic [ADDR_WIDTH-1:0]   mem_waddr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic                    mem_ren,
    output logic [ADDR_WIDTH-1:0]   mem_raddr,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic [N_HARTS-1:0]      hart_stall,
    output logic [N_HARTS-1:0]      hart_rst,
    output logic                    busy
);
    localparam int W  = DATA_WIDTH / 8;
    localparam int AL = $clog2(W);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST =
        TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    localparam logic [7:0] SYNC    = 8'hA5;
    localparam logic [7:0] ACK     = 8'h06;
    localparam logic [7:0] NAK     = 8'h15;
    localparam logic [7:0] PONG    = 8'h5A;
    localparam logic [7:0] C_PING  = 8'h01;
    localparam logic [7:0] C_CTRL  = 8'h02;
    localparam logic [7:0] C_WRITE = 8'h03;
    localparam logic [7:0] C_READ  = 8'h04;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ARG, S_WDATA, S_WRITE,
        S_RDREQ, S_RDWAIT, S_RDOUT, S_RESP
    } state_t;

    state_t state, state_nx;

    logic                  live;
    logic [7:0]            cmd_q;
    logic [7:0]            resp_q;
    logic                  pend_q;
    logic [2:0]            argc;
    logic [39:0]           arg_sr;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [15:0]           wcnt;
    logic [AL-1:0]         bcnt;
    logic [DATA_WIDTH-1:0] wbuf;
    logic [DATA_WIDTH-1:0] rbuf;
    logic [2:0]            lcnt;
    logic [TW-1:0]         tmo_cnt;

    logic        rx_st, acc, take, tmo;
    logic        arg_last, byte_last, word_last;
    logic [15:0] len_nx;
    logic [3:0]  hidx;
    logic        hidx_ok;
    logic        unused_arg;

    assign rx_st = state inside {S_IDLE, S_CMD, S_ARG, S_WDATA};
    assign in_ready  = live && rx_st;
    assign acc       = in_valid && in_ready;
    assign out_valid = state inside {S_RDOUT, S_RESP};
    assign take      = out_valid && out_ready;

    // Inter-byte timeout only while a frame is partially received.
    assign tmo = (TIMEOUT_CYCLES != 0) && rx_st && (state != S_IDLE)
                 && !acc && (tmo_cnt == TMO_LAST);

    assign arg_last  = (cmd_q == C_CTRL) || (argc == 3'd5);
    assign byte_last = bcnt == AL'(W - 1);
    assign word_last = wcnt == 16'd1;
    assign len_nx    = {in_data, arg_sr[39:32]};
    assign hidx      = in_data[7:4];
    assign hidx_ok   = (hidx == 4'hF) || (hidx < 4'(N_HARTS));
    assign unused_arg = ^arg_sr;

    assign mem_wen   = state == S_WRITE;
    assign mem_waddr = addr_q;
    assign mem_wdata = wbuf;
    assign mem_wstrb = '1;
    assign mem_ren   = state == S_RDREQ;
    assign mem_raddr = addr_q;
    assign busy      = state != S_IDLE;

    always_comb begin
        out_data = 8'h00;
        if (state == S_RDOUT) out_data = rbuf[7:0];
        else if (state == S_RESP) out_data = resp_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (acc && in_data == SYNC) state_nx = S_CMD;
            S_CMD: begin
                if (tmo) state_nx = S_RESP;
                else if (acc)
                    state_nx = (in_data inside {C_CTRL, C_WRITE, C_READ})
                               ? S_ARG : S_RESP;
            end
            S_ARG: begin
                if (tmo) state_nx = S_RESP;
                else if (acc && arg_last) begin
                    if (cmd_q == C_CTRL || len_nx == 16'd0) state_nx = S_RESP;
                    else if (cmd_q == C_WRITE) state_nx = S_WDATA;
                    else state_nx = S_RDREQ;
                end
            end
            S_WDATA: begin
                if (tmo) state_nx = S_RESP;
                else if (acc && byte_last) state_nx = S_WRITE;
            end
            S_WRITE:  state_nx = word_last ? S_RESP : S_WDATA;
            S_RDREQ:  state_nx = S_RDWAIT;
            S_RDWAIT: if (lcnt == 3'(RD_LATENCY)) state_nx = S_RDOUT;
            S_RDOUT: begin
                if (take && byte_last)
                    state_nx = word_last ? S_RESP : S_RDREQ;
            end
            S_RESP:   if (take && !pend_q) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live       <= 1'b0;
            cmd_q      <= '0;
            resp_q     <= '0;
            pend_q     <= 1'b0;
            argc       <= '0;
            arg_sr     <= '0;
            addr_q     <= '0;
            wcnt       <= '0;
            bcnt       <= '0;
            wbuf       <= '0;
            rbuf       <= '0;
            lcnt       <= '0;
            tmo_cnt    <= '0;
            hart_stall <= {N_HARTS{RESET_STALL}};
            hart_rst   <= '1;
        end else begin
            live    <= 1'b1;
            tmo_cnt <= (acc || !rx_st) ? '0 : tmo_cnt + TW'(1);
            unique case (state)
                S_IDLE: begin
                    if (acc && in_data == SYNC) begin
                        argc   <= '0;
                        bcnt   <= '0;
                        pend_q <= 1'b0;
                    end
                end
                S_CMD: begin
                    if (acc) begin
                        cmd_q  <= in_data;
                        pend_q <= in_data == C_PING;
                        resp_q <= (in_data == C_PING) ? PONG : NAK;
                    end else if (tmo) resp_q <= NAK;
                end
                S_ARG: begin
                    if (acc) begin
                        arg_sr <= {in_data, arg_sr[39:8]};
                        argc   <= argc + 3'd1;
                        if (arg_last) begin
                            resp_q <= ACK;
                            if (cmd_q == C_CTRL) begin
                                if (!hidx_ok) resp_q <= NAK;
                                else begin
                                    for (int i = 0; i < N_HARTS; i++) begin
                                        if (hidx == 4'hF || hidx == 4'(i)) begin
                                            hart_stall[i] <= in_data[0];
                                            hart_rst[i]   <= in_data[1];
                                        end
                                    end
                                end
                            end else begin
                                addr_q <= {arg_sr[ADDR_WIDTH-1:AL], {AL{1'b0}}};
                                wcnt   <= len_nx;
                            end
                        end
                    end else if (tmo) resp_q <= NAK;
                end
                S_WDATA: begin
                    if (acc) begin
                        wbuf <= {in_data, wbuf[DATA_WIDTH-1:8]};
                        bcnt <= bcnt + AL'(1);
                    end else if (tmo) resp_q <= NAK;
                end
                S_WRITE: begin
                    addr_q <= addr_q + ADDR_WIDTH'(W);
                    wcnt   <= wcnt - 16'd1;
                end
                S_RDREQ: lcnt <= 3'd1;
                S_RDWAIT: begin
                    if (lcnt == 3'(RD_LATENCY)) rbuf <= mem_rdata;
                    else lcnt <= lcnt + 3'd1;
                end
                S_RDOUT: begin
                    if (take) begin
                        rbuf <= {8'h00, rbuf[DATA_WIDTH-1:8]};
                        bcnt <= bcnt + AL'(1);
                        if (byte_last) begin
                            addr_q <= addr_q + ADDR_WIDTH'(W);
                            wcnt   <= wcnt - 16'd1;
                        end
                    end
                end
                S_RESP: begin
                    if (take && pend_q) begin
                        resp_q <= ACK;
                        pend_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_svc_rv_dbg_loader_mc.sv
// Bench for svc_rv_dbg_loader_mc: scoreboard of expected TX bytes and
// memory strobes, checked by a monitor as the DUT produces them.
module tb_svc_rv_dbg_loader_mc;
    localparam int RDL = 2;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b1;
    logic        mem_wen;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ren;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic [3:0]  hart_stall;
    logic [3:0]  hart_rst;
    logic        busy;

    int total = 0;
    int bad = 0;
    int nout = 0;

    logic [7:0]  exp_out[$];
    logic [63:0] exp_wr[$];
    logic [31:0] exp_rd[$];
    logic [7:0]  fq[$];
    logic [31:0] pa[RDL];
    logic [3:0]  m_stall = 4'hF;
    logic [3:0]  m_rst = 4'hF;

    always #5 clk = ~clk;

    svc_rv_dbg_loader_mc #(
        .N_HARTS(4), .DATA_WIDTH(32), .ADDR_WIDTH(32),
        .RD_LATENCY(RDL), .TIMEOUT_CYCLES(100), .RESET_STALL(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ren(mem_ren), .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata), .hart_stall(hart_stall),
        .hart_rst(hart_rst), .busy(busy)
    );

    function automatic logic [31:0] rmodel(input logic [31:0] a);
        return a ^ 32'hC3A5_5A3C ^ {a[15:0], a[31:16]};
    endfunction

    always @(posedge clk) begin
        pa[0] <= mem_raddr;
        pa[1] <= pa[0];
    end
    assign mem_rdata = rmodel(pa[RDL-1]);

    task automatic monitor();
        logic [7:0]  e;
        logic [63:0] w;
        logic [31:0] r;
        logic        hold_v = 1'b0;
        logic [7:0]  hold_d = 8'h00;
        forever begin
            @(negedge clk);
            if (out_valid && !out_ready) begin
                if (hold_v) begin
                    total++;
                    if (out_data !== hold_d) begin
                        bad++;
                        $display("FAIL out_stable got=%02h exp=%02h", out_data, hold_d);
                    end
                end
                hold_v = 1'b1;
                hold_d = out_data;
            end else hold_v = 1'b0;
            if (out_valid && out_ready) begin
                total++;
                nout++;
                if (exp_out.size() == 0) begin
                    bad++;
                    $display("FAIL out_extra got=%02h exp=none", out_data);
                end else begin
                    e = exp_out.pop_front();
                    if (out_data !== e) begin
                        bad++;
                        $display("FAIL out_byte got=%02h exp=%02h", out_data, e);
                    end
                end
            end
            if (mem_wen) begin
                total++;
                if (exp_wr.size() == 0) begin
                    bad++;
                    $display("FAIL wr_extra got=%08h:%08h exp=none", mem_waddr, mem_wdata);
                end else begin
                    w = exp_wr.pop_front();
                    if ({mem_waddr, mem_wdata} !== w || mem_wstrb !== 4'hF) begin
                        bad++;
                        $display("FAIL wr got=%08h:%08h/%h exp=%08h:%08h/f",
                                 mem_waddr, mem_wdata, mem_wstrb, w[63:32], w[31:0]);
                    end
                end
            end
            if (mem_ren) begin
                total++;
                if (exp_rd.size() == 0) begin
                    bad++;
                    $display("FAIL rd_extra got=%08h exp=none", mem_raddr);
                end else begin
                    r = exp_rd.pop_front();
                    if (mem_raddr !== r) begin
                        bad++;
                        $display("FAIL rd_addr got=%08h exp=%08h", mem_raddr, r);
                    end
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL in_stall got=ready0 exp=ready1 byte=%02h", b);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_fq();
        foreach (fq[i]) send_byte(fq[i]);
        fq.delete();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_out.size() != 0 || exp_wr.size() != 0 ||
                exp_rd.size() != 0 || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 500) begin
            bad++;
            $display("FAIL %s drain got=out%0d/wr%0d/rd%0d/busy%0b exp=empty",
                     name, exp_out.size(), exp_wr.size(), exp_rd.size(), busy);
            exp_out.delete();
            exp_wr.delete();
            exp_rd.delete();
        end
    endtask

    task automatic check_harts(input string name);
        total++;
        if (hart_stall !== m_stall || hart_rst !== m_rst) begin
            bad++;
            $display("FAIL %s got=stall%h/rst%h exp=stall%h/rst%h",
                     name, hart_stall, hart_rst, m_stall, m_rst);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
            mem_wen !== 1'b0 || mem_ren !== 1'b0 || out_data !== 8'h00 ||
            mem_waddr !== 32'h0 || mem_wdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_out got=rdy%b ov%b busy%b wen%b ren%b od%02h exp=0",
                     in_ready, out_valid, busy, mem_wen, mem_ren, out_data);
        end
        check_harts("reset_harts");
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_ping();
        send_byte(8'h33);
        exp_out.push_back(8'h5A);
        exp_out.push_back(ACK);
        fq = '{8'hA5, 8'h01};
        send_fq();
        drain("ping");
    endtask

    task automatic do_ctrl(input logic [7:0] a);
        logic [3:0] ix;
        ix = a[7:4];
        if (ix == 4'hF) begin
            m_stall = {4{a[0]}};
            m_rst   = {4{a[1]}};
            exp_out.push_back(ACK);
        end else if (ix < 4'd4) begin
            m_stall[ix[1:0]] = a[0];
            m_rst[ix[1:0]]   = a[1];
            exp_out.push_back(ACK);
        end else exp_out.push_back(NAK);
        fq = '{8'hA5, 8'h02, a};
        send_fq();
        drain("ctrl");
        check_harts("ctrl_harts");
    endtask

    task automatic test_ctrl();
        do_ctrl(8'h21);
        do_ctrl(8'hF0);
        do_ctrl(8'h50);
        do_ctrl(8'h13);
    endtask

    task automatic do_write(input logic [31:0] a, input int len, input int seed);
        logic [31:0] wa;
        logic [31:0] d;
        wa = {a[31:2], 2'b00};
        fq = '{8'hA5, 8'h03, a[7:0], a[15:8], a[23:16], a[31:24],
               8'(len), 8'(len >> 8)};
        for (int k = 0; k < len; k++) begin
            d = 32'(seed) * 32'h0101_0101 + 32'(k) * 32'h1357_9BDF;
            for (int j = 0; j < 4; j++) fq.push_back(d[8*j +: 8]);
            exp_wr.push_back({wa, d});
            wa = wa + 32'd4;
        end
        exp_out.push_back(ACK);
        send_fq();
        drain("write");
    endtask

    task automatic test_write();
        exp_wr.push_back({32'h0000_1000, 32'h4433_2211});
        exp_wr.push_back({32'h0000_1004, 32'h8877_6655});
        exp_out.push_back(ACK);
        fq = '{8'hA5, 8'h03, 8'h00, 8'h10, 8'h00, 8'h00, 8'h02, 8'h00,
               8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_fq();
        drain("write_basic");
        do_write(32'h0000_1003, 1, 7);
        do_write(32'hFFFF_FFFC, 2, 9);
        do_write(32'h0000_4000, 0, 1);
    endtask

    task automatic do_read(input logic [31:0] a, input int len, input bit stall);
        logic [31:0] ra;
        logic [31:0] d;
        int n = 0;
        int tgt;
        ra = {a[31:2], 2'b00};
        for (int k = 0; k < len; k++) begin
            d = rmodel(ra);
            exp_rd.push_back(ra);
            for (int j = 0; j < 4; j++) exp_out.push_back(d[8*j +: 8]);
            ra = ra + 32'd4;
        end
        exp_out.push_back(ACK);
        tgt = nout + 3;
        fq = '{8'hA5, 8'h04, a[7:0], a[15:8], a[23:16], a[31:24],
               8'(len), 8'(len >> 8)};
        send_fq();
        if (stall) begin
            while (nout < tgt && n < 300) begin
                @(posedge clk);
                n++;
            end
            #1 out_ready = 1'b0;
            repeat (10) @(posedge clk);
            #1 out_ready = 1'b1;
        end
        drain("read");
    endtask

    task automatic test_read();
        do_read(32'h0000_1000, 2, 1'b1);
        do_read(32'hFFFF_FFFC, 2, 1'b0);
        do_read(32'h0000_2000, 0, 1'b0);
    endtask

    task automatic test_errors();
        exp_out.push_back(NAK);
        fq = '{8'hA5, 8'h7E};
        send_fq();
        drain("bad_cmd");
        exp_out.push_back(NAK);
        fq = '{8'hA5, 8'h03, 8'h00, 8'h10};
        send_fq();
        drain("timeout_arg");
        exp_wr.push_back({32'h0000_2000, 32'hD4C3_B2A1});
        exp_out.push_back(NAK);
        fq = '{8'hA5, 8'h03, 8'h00, 8'h20, 8'h00, 8'h00, 8'h02, 8'h00,
               8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
        send_fq();
        drain("timeout_data");
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL timeout_idle got=busy%b rdy%b exp=busy0 rdy1", busy, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        exp_out.push_back(8'h5A);
        exp_out.push_back(ACK);
        exp_out.push_back(NAK);
        exp_out.push_back(8'h5A);
        exp_out.push_back(ACK);
        fq = '{8'hA5, 8'h01, 8'hA5, 8'h7E, 8'hA5, 8'h01};
        send_fq();
        drain("b2b");
    endtask

    task automatic test_reset_mid();
        fq = '{8'hA5, 8'h03, 8'h00, 8'h30, 8'h00, 8'h00, 8'h01, 8'h00,
               8'h11, 8'h22};
        send_fq();
        @(negedge clk);
        rst_n = 1'b0;
        m_stall = 4'hF;
        m_rst   = 4'hF;
        #1;
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || mem_wen !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got=busy%b rdy%b wen%b exp=0", busy, in_ready, mem_wen);
        end
        check_harts("mid_reset_harts");
        @(negedge clk);
        rst_n = 1'b1;
        test_ping();
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_ping();
        test_ctrl();
        test_write();
        test_read();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        repeat (20) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
